// File: rtl/shift_pkg.sv
// Shared types for the shift/rotate pipeline: op encoding, stage-1 payload,
// and the direction helper used to steer the rotator.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_SRA = 3'd4
  } shift_op_e;

  // Op field is kept as raw bits so illegal encodings survive to stage 2.
  typedef struct packed {
    logic [31:0] num;
    logic [4:0]  amt;
    logic [2:0]  op;
    logic        sign;
  } s1_t;

  function automatic logic is_right(shift_op_e op);
    return (op == OP_ROR) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_op_pipe_barrel.sv
// 32-bit combinational rotator: lr_i=1 rotates right, lr_i=0 rotates left,
// by amt_i positions (0..31), built as five conditional power-of-two stages.
module thirtyTwoBitBarrelShifter (
  input  logic [31:0] num_i,
  input  logic [4:0]  amt_i,
  input  logic        lr_i,
  output logic [31:0] res_o
);

  logic [31:0] stage_v;

  // Log-depth rotate: stage i rotates by 2^i when amt_i[i] is set.
  always_comb begin
    stage_v = num_i;
    for (int unsigned i = 0; i < 5; i++) begin
      if (amt_i[i]) begin
        if (lr_i) begin
          stage_v = (stage_v >> (1 << i)) | (stage_v << (32 - (1 << i)));
        end else begin
          stage_v = (stage_v << (1 << i)) | (stage_v >> (32 - (1 << i)));
        end
      end
    end
  end

  assign res_o = stage_v;

endmodule

// File: rtl/shift_op_pipe.sv
// Two-stage valid/ready shift/rotate pipeline. Stage 1 registers the request
// and feeds the rotator; stage 2 masks the rotated word into the final
// ROL/ROR/SLL/SRL/SRA result and registers it with tag, zero and error flags.
module shift_op_pipe
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_num,
  input  logic [4:0]       in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  s1_t              s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_res_q, s2_res_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv;
  logic             lr;
  logic [31:0]      rot, mask_l, mask_r, res_c;
  logic             err_c;

  // Each stage may load when empty or when its contents move on this cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign lr = is_right(shift_op_e'(s1_q.op));

  thirtyTwoBitBarrelShifter u_rot (
    .num_i (s1_q.num),
    .amt_i (s1_q.amt),
    .lr_i  (lr),
    .res_o (rot)
  );

  // Stage 1 next state: capture the request whenever the stage can advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s1_tag_d   = s1_tag_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.num  = in_num;
        s1_d.amt  = in_amt;
        s1_d.op   = in_op;
        s1_d.sign = in_num[31];
        s1_tag_d  = in_tag;
      end
    end
  end

  // Stage 2 datapath: shifts are rotations with the wrapped bits masked off.
  always_comb begin
    mask_l = 32'hFFFF_FFFF << s1_q.amt;
    mask_r = 32'hFFFF_FFFF >> s1_q.amt;
    res_c  = s1_q.num;
    err_c  = 1'b0;
    case (shift_op_e'(s1_q.op))
      OP_ROL, OP_ROR: res_c = rot;
      OP_SLL:         res_c = rot & mask_l;
      OP_SRL:         res_c = rot & mask_r;
      OP_SRA:         res_c = (rot & mask_r) | ({32{s1_q.sign}} & ~mask_r);
      default: begin
        res_c = s1_q.num;
        err_c = 1'b1;
      end
    endcase
  end

  // Stage 2 next state: load the result when the output slot frees up.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;
    s2_zero_d  = s2_zero_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d  = res_c;
        s2_tag_d  = s1_tag_q;
        s2_zero_d = (res_c == 32'h0);
        s2_err_d  = err_c;
      end
    end
  end

  // Completed-op counter, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
      s2_zero_q  <= s2_zero_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_tag   = s2_tag_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;
  assign op_count  = cnt_q;

endmodule
